// File: rtl/bf16_operand_feeder_if.sv
// Byte-in / bf16-pair-out stream bundle between the pin deserialiser and the systolic cell.
// The slave side is the feeder; the master side is the byte source plus the cell consuming A/B.
interface bf16_operand_feeder_if;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic        out_valid;
   logic        out_ready;

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output in_ready,
      output A,
      output B,
      output out_valid
   );

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  in_ready,
      input  A,
      input  B,
      input  out_valid
   );
endinterface

// File: rtl/bf16_operand_feeder.sv
// Assembles 4-byte bf16 A/B pairs into a DEPTH-entry FIFO; a pair is visible the cycle after its last byte.
// Only the completing byte is back-pressured (FIFO full); in_ready is registered-state only, no path from out_ready.
module bf16_operand_feeder #(
   parameter  int DEPTH = 4,
   parameter  int CNT_W = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   bf16_operand_feeder_if.slave bus,
   output logic [LW-1:0]        level,
   output logic [CNT_W-1:0]     pair_count
);

   typedef enum logic [1:0] {
      PH_AH = 2'd0,
      PH_AL = 2'd1,
      PH_BH = 2'd2,
      PH_BL = 2'd3
   } phase_e;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
   } pair_t;

   phase_e            phase_q, phase_d;
   logic [7:0]        a_hi_q, a_hi_d;
   logic [7:0]        a_lo_q, a_lo_d;
   logic [7:0]        b_hi_q, b_hi_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   pair_t             mem_q [DEPTH];

   logic              full;
   logic              out_vld;
   logic              in_rdy;
   logic              accept;
   logic              push;
   logic              pop;
   pair_t             head;

   assign full    = (level_q == LW'(DEPTH));
   assign out_vld = (level_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= PH_AH;
         a_hi_q  <= '0;
         a_lo_q  <= '0;
         b_hi_q  <= '0;
      end else begin
         phase_q <= phase_d;
         a_hi_q  <= a_hi_d;
         a_lo_q  <= a_lo_d;
         b_hi_q  <= b_hi_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (flush) begin
         phase_d = PH_AH;
      end else if (accept) begin
         case (phase_q)
            PH_AH:   phase_d = PH_AL;
            PH_AL:   phase_d = PH_BH;
            PH_BH:   phase_d = PH_BL;
            default: phase_d = PH_AH;
         endcase
      end
   end

   // Holding registers keep their contents through flush; only reset clears them.
   always_comb begin
      in_rdy = !flush && ((phase_q != PH_BL) || !full);
      accept = bus.in_valid && in_rdy;
      push   = accept && (phase_q == PH_BL);
      a_hi_d = a_hi_q;
      a_lo_d = a_lo_q;
      b_hi_d = b_hi_q;
      if (accept) begin
         case (phase_q)
            PH_AH:   a_hi_d = bus.in_data;
            PH_AL:   a_lo_d = bus.in_data;
            PH_BH:   b_hi_d = bus.in_data;
            default: ;
         endcase
      end
   end

   assign bus.in_ready = in_rdy;

   assign pop = out_vld && bus.out_ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
      cnt_d    = cnt_q + CNT_W'(pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage is not reset: entries are only observable while level is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{a: {a_hi_q, a_lo_q}, b: {b_hi_q, bus.in_data}};
      end
   end

   assign head          = mem_q[rd_ptr_q];
   assign bus.A         = out_vld ? head.a : 16'h0000;
   assign bus.B         = out_vld ? head.b : 16'h0000;
   assign bus.out_valid = out_vld;
   assign level         = level_q;
   assign pair_count    = cnt_q;

endmodule

// File: tb/tb_bf16_operand_feeder.sv
// Scoreboard bench: expected pairs are queued as bytes are driven and compared as the cell side pops them.
module tb_bf16_operand_feeder;
   localparam int DEPTH = 4;
   localparam int CNT_W = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic [LW-1:0]     level;
   logic [CNT_W-1:0]  pair_count;

   bf16_operand_feeder_if bus ();

   bf16_operand_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .bus        (bus),
      .level      (level),
      .pair_count (pair_count)
   );

   always #5 clk = ~clk;

   int               n_chk = 0;
   int               n_err = 0;
   logic [31:0]      sb [$];
   logic [CNT_W-1:0] exp_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit acc = 1'b0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk);
         acc = bus.in_ready;
         step();
      end
      bus.in_valid = 1'b0;
      chk("byte_accept", 32'(acc), 32'd1);
   endtask

   task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
      send_byte(b[15:8]);
      send_byte(b[7:0]);
      sb.push_back({a, b});
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int t = 0; t < 64 && (level != '0 || sb.size() != 0); t++) step();
      chk("drain_level", 32'(level), 32'd0);
      chk("drain_sb", 32'(sb.size()), 32'd0);
      bus.out_ready = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_A"}, 32'(bus.A), 32'd0);
      chk({tag, "_B"}, 32'(bus.B), 32'd0);
      chk({tag, "_level"}, 32'(level), 32'd0);
      chk({tag, "_pair_count"}, 32'(pair_count), 32'd0);
   endtask

   // Cell-side monitor: a pop happens at the next edge whenever valid&&ready is seen here.
   always @(negedge clk) begin
      if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_pop", 32'(bus.out_valid), 32'd0);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("pop_A", 32'(bus.A), 32'(e[31:16]));
            chk("pop_B", 32'(bus.B), 32'(e[15:0]));
            exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [15:0] pa, pb;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      #12;
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      step();

      // Single pair, consumer always ready
      bus.out_ready = 1'b1;
      send_pair(16'h3F80, 16'h3F80);
      @(negedge clk);
      chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t1_A", 32'(bus.A), 32'h3F80);
      chk("t1_B", 32'(bus.B), 32'h3F80);
      step();
      @(negedge clk);
      chk("t1_empty_valid", 32'(bus.out_valid), 32'd0);
      chk("t1_empty_A", 32'(bus.A), 32'd0);
      chk("t1_empty_B", 32'(bus.B), 32'd0);
      chk("t1_pair_count", 32'(pair_count), 32'd1);
      step();

      // Fill to full, then back-pressure only the completing byte
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_pair(16'h4000 + 16'(i), 16'h3F80);
      @(negedge clk);
      chk("full_level", 32'(level), 32'(DEPTH));
      chk("full_ready_ah", 32'(bus.in_ready), 32'd1);
      step();
      send_byte(8'h40);
      send_byte(8'h04);
      send_byte(8'h3F);
      bus.in_data  = 8'h80;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("bl_full_ready0", 32'(bus.in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("bl_full_ready1", 32'(bus.in_ready), 32'd0);
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bl_ready_before_pop", 32'(bus.in_ready), 32'd0);
      step();
      @(negedge clk);
      chk("bl_ready_after_pop", 32'(bus.in_ready), 32'd1);
      step();
      bus.in_valid = 1'b0;
      sb.push_back({16'h4004, 16'h3F80});
      drain();
      chk("t2_pair_count", 32'(pair_count), 32'(exp_cnt));

      // Hold level at 3 with simultaneous push/pop across several pointer wraps
      for (int i = 0; i < 3; i++) send_pair(16'h5000 + 16'(i), 16'h6000 + 16'(i));
      @(negedge clk);
      chk("pp_start_level", 32'(level), 32'd3);
      step();
      for (int i = 0; i < 3 * DEPTH; i++) begin
         pa = 16'h5100 + 16'(i);
         pb = 16'h6100 + 16'(i);
         send_byte(pa[15:8]);
         send_byte(pa[7:0]);
         send_byte(pb[15:8]);
         bus.in_data   = pb[7:0];
         bus.in_valid  = 1'b1;
         bus.out_ready = 1'b1;
         step();
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b0;
         sb.push_back({pa, pb});
         @(negedge clk);
         chk("pp_level", 32'(level), 32'd3);
         step();
      end
      drain();

      // Flush mid-pair with a stored entry and a byte offered in the same cycle
      send_pair(16'h7000, 16'h7001);
      send_byte(8'h12);
      send_byte(8'h34);
      bus.in_data  = 8'h56;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(negedge clk);
      chk("flush_ready", 32'(bus.in_ready), 32'd0);
      step();
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      exp_cnt = '0;
      @(negedge clk);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_pair_count", 32'(pair_count), 32'd0);
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      step();
      send_pair(16'h3FC0, 16'h4040);
      drain();

      // Asynchronous reset mid-pair with two entries stored
      send_pair(16'h1111, 16'h2222);
      send_pair(16'h3333, 16'h4444);
      send_byte(8'h55);
      send_byte(8'h66);
      chk("pre_rst_level", 32'(level), 32'd2);
      #2;
      rst_n = 1'b0;
      sb.delete();
      exp_cnt = '0;
      #1;
      chk_reset_outputs("arst");
      #3;
      rst_n = 1'b1;
      step();
      send_pair(16'h3F80, 16'hBF80);
      drain();
      chk("post_rst_pair_count", 32'(pair_count), 32'd1);

      // Counter wrap after 256 pops
      bus.out_ready = 1'b1;
      for (int i = 0; i < 255; i++) send_pair(16'(i), ~16'(i));
      drain();
      chk("pc_wrap", 32'(pair_count), 32'd0);
      chk("pc_model", 32'(pair_count), 32'(exp_cnt));

      // Popping an empty FIFO must not disturb pointers or level
      bus.out_ready = 1'b1;
      repeat (5) step();
      @(negedge clk);
      chk("empty_pop_level", 32'(level), 32'd0);
      chk("empty_pop_valid", 32'(bus.out_valid), 32'd0);
      step();
      bus.out_ready = 1'b0;
      send_pair(16'hABCD, 16'h1234);
      @(negedge clk);
      chk("head_after_empty_pop_A", 32'(bus.A), 32'hABCD);
      chk("head_after_empty_pop_B", 32'(bus.B), 32'h1234);
      chk("head_after_empty_pop_level", 32'(level), 32'd1);
      step();
      drain();

      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
